// File: rtl/dice_turn_scheduler_pkg.sv
// Shared types and constants for the two-player dice turn scheduler.
// Optional turn timeout is enabled with DICE_SCHED_TIMEOUT_EN.
package dice_pkg;

    localparam int DIE_W = 3;
    localparam int SUM_W = 4;

    localparam logic [DIE_W-1:0] DIE_MIN = 3'd1;
    localparam logic [DIE_W-1:0] DIE_MAX = 3'd6;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_WAIT_BTN,
        S_STROBE,
        S_SETTLE,
        S_RESOLVE,
        S_OVER
    } sched_state_t;

    function automatic logic [DIE_W-1:0] die_next(
        input logic [DIE_W-1:0] d
    );
        return (d == DIE_MAX) ? DIE_MIN : d + DIE_W'(1);
    endfunction

endpackage

// File: rtl/dice_turn_scheduler_if.sv
// Bundle between the scheduler, the button synchronizers and the game core.
// Optional turn timeout is enabled with DICE_SCHED_TIMEOUT_EN.
interface dice_turn_scheduler_if #(
    parameter int SCORE_W = 4
);
    import dice_pkg::*;

    logic               btn_p0;
    logic               btn_p1;
    logic               core_win;
    logic               core_lose;
    logic [SUM_W-1:0]   core_sum;
    logic               core_rb;
    logic               core_rst;
    logic [DIE_W-1:0]   die_a;
    logic [DIE_W-1:0]   die_b;
    logic               active_player;
    logic [SCORE_W-1:0] score0;
    logic [SCORE_W-1:0] score1;
    logic               match_over;
    logic               champion;

    modport master (
        input  btn_p0, btn_p1, core_win, core_lose,
        output core_sum, core_rb, core_rst, die_a, die_b,
        output active_player, score0, score1,
        output match_over, champion
    );

    modport slave (
        output btn_p0, btn_p1, core_win, core_lose,
        input  core_sum, core_rb, core_rst, die_a, die_b,
        input  active_player, score0, score1,
        input  match_over, champion
    );

endinterface

// File: rtl/dice_turn_scheduler_roller.sv
// Free-running chained mod-6 dice counters with latched roll outputs.
// Optional turn timeout is enabled with DICE_SCHED_TIMEOUT_EN.
module dice_roller
    import dice_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_latch,
    output logic [DIE_W-1:0] o_die_a,
    output logic [DIE_W-1:0] o_die_b,
    output logic [SUM_W-1:0] o_sum
);

    logic [DIE_W-1:0] r_ra;
    logic [DIE_W-1:0] r_rb;

    // ra steps every clock; rb steps when ra wraps, covering all 36 pairs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ra <= DIE_MIN;
            r_rb <= DIE_MIN;
        end else begin
            r_ra <= die_next(r_ra);
            if (r_ra == DIE_MAX) begin
                r_rb <= die_next(r_rb);
            end
        end
    end

    // capture the current pair and its sum when a roll is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            o_die_a <= DIE_MIN;
            o_die_b <= DIE_MIN;
            o_sum   <= '0;
        end else if (i_latch) begin
            o_die_a <= r_ra;
            o_die_b <= r_rb;
            o_sum   <= SUM_W'(r_ra) + SUM_W'(r_rb);
        end
    end

endmodule

// File: rtl/dice_turn_scheduler.sv
// Two-player turn controller driving the dual-dice game core.
// Define DICE_SCHED_TIMEOUT_EN to forfeit idle turns after TIMEOUT_CYC cycles.
module dice_turn_scheduler
    import dice_pkg::*;
#(
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 5,
    parameter int RB_CYC      = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic                    clk,
    input logic                    rst,
    dice_turn_scheduler_if.master  bus
);

    localparam int CW = (RB_CYC > 1) ? $clog2(RB_CYC) : 1;

    if (RB_CYC < 1) begin : g_bad_rb
        $error("RB_CYC must be at least 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_to
        $error("TIMEOUT_CYC must be at least 1");
    end

    sched_state_t       r_state;
    sched_state_t       w_next;
    logic [1:0]         r_btn_prev;
    logic [CW-1:0]      r_cnt;
    logic [SCORE_W-1:0] r_score0;
    logic [SCORE_W-1:0] r_score1;
    logic               r_active;
    logic               r_scorer;
    logic               r_champion;

    logic [1:0]         w_btn;
    logic [1:0]         w_rise;
    logic               w_edge;
    logic               w_timeout;
    logic               w_latch;
    logic               w_inc;
    logic               w_inc_p;
    logic               w_toggle;
    logic               w_set_champ;
    logic [SCORE_W-1:0] w_cur_score;

    assign w_btn       = {bus.btn_p1, bus.btn_p0};
    assign w_rise      = w_btn & ~r_btn_prev;
    assign w_edge      = w_rise[r_active];
    assign w_cur_score = r_scorer ? r_score1 : r_score0;

`ifdef DICE_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_to_cnt;

    // idle counter, restarted every time WAIT_BTN is entered
    always_ff @(posedge clk) begin
        if (rst || r_state != S_WAIT_BTN) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign w_timeout = (r_to_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // next-state and per-cycle control decisions
    always_comb begin
        w_next      = r_state;
        w_latch     = 1'b0;
        w_inc       = 1'b0;
        w_inc_p     = r_active;
        w_toggle    = 1'b0;
        w_set_champ = 1'b0;
        unique case (r_state)
            S_CLEAR: begin
                w_next = S_WAIT_BTN;
            end
            S_WAIT_BTN: begin
                if (w_edge) begin
                    w_latch = 1'b1;
                    w_next  = S_STROBE;
                end else if (w_timeout) begin
                    w_toggle = 1'b1;
                    w_next   = S_CLEAR;
                end
            end
            S_STROBE: begin
                if (r_cnt == CW'(RB_CYC - 1)) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.core_lose) begin
                    w_inc   = 1'b1;
                    w_inc_p = ~r_active;
                    w_next  = S_RESOLVE;
                end else if (bus.core_win) begin
                    w_inc  = 1'b1;
                    w_next = S_RESOLVE;
                end else begin
                    w_next = S_WAIT_BTN;
                end
            end
            S_RESOLVE: begin
                if (w_cur_score == SCORE_W'(WIN_SCORE)) begin
                    w_set_champ = 1'b1;
                    w_next      = S_OVER;
                end else begin
                    w_toggle = 1'b1;
                    w_next   = S_CLEAR;
                end
            end
            S_OVER: begin
                w_next = S_OVER;
            end
            default: begin
                w_next = S_CLEAR;
            end
        endcase
    end

    // state, strobe timer, scores and player bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_CLEAR;
            r_btn_prev <= '0;
            r_cnt      <= '0;
            r_score0   <= '0;
            r_score1   <= '0;
            r_active   <= 1'b0;
            r_scorer   <= 1'b0;
            r_champion <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_btn_prev <= w_btn;
            r_cnt      <= (r_state == S_STROBE) ? r_cnt + CW'(1) : '0;
            if (w_inc) begin
                r_scorer <= w_inc_p;
                if (w_inc_p) begin
                    r_score1 <= r_score1 + SCORE_W'(1);
                end else begin
                    r_score0 <= r_score0 + SCORE_W'(1);
                end
            end
            if (w_toggle) begin
                r_active <= ~r_active;
            end
            if (w_set_champ) begin
                r_champion <= r_scorer;
            end
        end
    end

    dice_roller u_roller (
        .clk     (clk),
        .rst     (rst),
        .i_latch (w_latch),
        .o_die_a (bus.die_a),
        .o_die_b (bus.die_b),
        .o_sum   (bus.core_sum)
    );

    assign bus.core_rb       = (r_state == S_STROBE);
    assign bus.core_rst      = rst | (r_state == S_CLEAR);
    assign bus.match_over    = (r_state == S_OVER);
    assign bus.active_player = r_active;
    assign bus.score0        = r_score0;
    assign bus.score1        = r_score1;
    assign bus.champion      = r_champion;

endmodule

// File: tb/tb_dice_turn_scheduler.sv
// Directed scoreboard bench for dice_turn_scheduler.
// Define DICE_SCHED_TIMEOUT_EN to also exercise the turn timeout.
module tb_dice_turn_scheduler;

    localparam int SCORE_W = 4;
    localparam int RB_CYC  = 2;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [3:0] s;
    } roll_t;

    logic clk;
    logic rst;
    logic [2:0] m_ra;
    logic [2:0] m_rb;
    int checks;
    int failures;
    int exp_s0;
    int exp_s1;
    int exp_act;
    int exp_champ;
    roll_t sb[$];

    dice_turn_scheduler_if #(.SCORE_W(SCORE_W)) bus ();

    dice_turn_scheduler #(
        .SCORE_W     (SCORE_W),
        .WIN_SCORE   (5),
        .RB_CYC      (RB_CYC),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference dice roller
    always @(posedge clk) begin
        if (rst) begin
            m_ra <= 3'd1;
            m_rb <= 3'd1;
        end else begin
            m_ra <= (m_ra == 3'd6) ? 3'd1 : m_ra + 3'd1;
            if (m_ra == 3'd6) begin
                m_rb <= (m_rb == 3'd6) ? 3'd1 : m_rb + 3'd1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic roll(input bit p, input bit w, input bit l,
                        input bit hold);
        int n;
        roll_t e;
        e.a = m_ra;
        e.b = m_rb;
        e.s = {1'b0, m_ra} + {1'b0, m_rb};
        sb.push_back(e);
        if (p) bus.btn_p1 = 1'b1;
        else   bus.btn_p0 = 1'b1;
        @(negedge clk);
        if (!hold) begin
            bus.btn_p0 = 1'b0;
            bus.btn_p1 = 1'b0;
        end
        n = 0;
        while (bus.core_rb !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("rb_latency", n, 0);
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) e = sb.pop_front();
        chk("die_a", bus.die_a, e.a);
        chk("die_b", bus.die_b, e.b);
        n = 0;
        while (bus.core_rb === 1'b1 && n < 8) begin
            chk("core_sum", bus.core_sum, e.s);
            @(negedge clk);
            n++;
        end
        chk("rb_len", n, RB_CYC);
        bus.core_win  = w;
        bus.core_lose = l;
        @(negedge clk);
        bus.core_win  = 1'b0;
        bus.core_lose = 1'b0;
    endtask

    task automatic expect_after(input bit over);
        chk("score0", bus.score0, exp_s0);
        chk("score1", bus.score1, exp_s1);
        @(negedge clk);
        if (over) begin
            chk("match_over", bus.match_over, 1);
            chk("champion", bus.champion, exp_champ);
            chk("rb_in_over", bus.core_rb, 0);
        end else begin
            chk("rst_pulse", bus.core_rst, 1);
            chk("active", bus.active_player, exp_act);
            @(negedge clk);
            chk("rst_end", bus.core_rst, 0);
        end
    endtask

    task automatic idle_no_rb(input string tag, input int cyc);
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            chk(tag, bus.core_rb, 0);
        end
    endtask

    task automatic do_reset(input int cyc);
        rst = 1'b1;
        repeat (cyc) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_s0 = 0;
        exp_s1 = 0;
        exp_act = 0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 5)) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        exp_s0 = 0;
        exp_s1 = 0;
        exp_act = 0;
        exp_champ = 0;
        rst = 1'b1;
        bus.btn_p0 = 1'b0;
        bus.btn_p1 = 1'b0;
        bus.core_win = 1'b0;
        bus.core_lose = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_die_a", bus.die_a, 1);
        chk("rst_die_b", bus.die_b, 1);
        chk("rst_sum", bus.core_sum, 0);
        chk("rst_rb", bus.core_rb, 0);
        chk("rst_score0", bus.score0, 0);
        chk("rst_score1", bus.score1, 0);
        chk("rst_active", bus.active_player, 0);
        chk("rst_over", bus.match_over, 0);
        chk("rst_champ", bus.champion, 0);
        chk("rst_core_rst", bus.core_rst, 1);
        rst = 1'b0;
        #1;
        chk("clear_core_rst", bus.core_rst, 1);
        @(negedge clk);
        chk("wait_core_rst", bus.core_rst, 0);

`ifdef DICE_SCHED_TIMEOUT_EN
        repeat (15) @(negedge clk);
        chk("to_early_active", bus.active_player, 0);
        chk("to_early_rst", bus.core_rst, 0);
        @(negedge clk);
        chk("to_rst_pulse", bus.core_rst, 1);
        chk("to_active", bus.active_player, 1);
        chk("to_score0", bus.score0, 0);
        chk("to_score1", bus.score1, 0);
        do_reset(1);
`endif

        // point phase with button held, then ignored opponent edge
        roll(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pt_active", bus.active_player, 0);
        chk("pt_score0", bus.score0, 0);
        chk("pt_core_rst", bus.core_rst, 0);
        idle_no_rb("held_btn", 4);
        bus.btn_p0 = 1'b0;
        bus.btn_p1 = 1'b1;
        idle_no_rb("other_btn", 5);
        bus.btn_p1 = 1'b0;
        chk("arb_active", bus.active_player, 0);

        roll(1'b0, 1'b1, 1'b0, 1'b0);
        exp_s0 = 1; exp_act = 1;
        expect_after(1'b0);

        gap();
        roll(1'b1, 1'b1, 1'b1, 1'b0);
        exp_s0 = 2; exp_act = 0;
        expect_after(1'b0);

        gap();
        roll(1'b0, 1'b0, 1'b1, 1'b0);
        exp_s1 = 1; exp_act = 1;
        expect_after(1'b0);

        gap();
        roll(1'b1, 1'b1, 1'b0, 1'b0);
        exp_s1 = 2; exp_act = 0;
        expect_after(1'b0);

        gap();
        roll(1'b0, 1'b0, 1'b1, 1'b0);
        exp_s1 = 3; exp_act = 1;
        expect_after(1'b0);

        gap();
        roll(1'b1, 1'b1, 1'b0, 1'b0);
        exp_s1 = 4; exp_act = 0;
        expect_after(1'b0);

        gap();
        roll(1'b0, 1'b1, 1'b0, 1'b0);
        exp_s0 = 3; exp_act = 1;
        expect_after(1'b0);

        gap();
        roll(1'b1, 1'b1, 1'b0, 1'b0);
        exp_s1 = 5; exp_champ = 1;
        expect_after(1'b1);

        bus.btn_p1 = 1'b1;
        idle_no_rb("over_p1", 2);
        bus.btn_p1 = 1'b0;
        bus.btn_p0 = 1'b1;
        idle_no_rb("over_p0", 2);
        bus.btn_p0 = 1'b0;
        @(negedge clk);
        bus.btn_p1 = 1'b1;
        idle_no_rb("over_p1b", 2);
        bus.btn_p1 = 1'b0;
        chk("over_hold", bus.match_over, 1);
        chk("over_score1", bus.score1, 5);

        do_reset(2);
        chk("rr_score0", bus.score0, 0);
        chk("rr_score1", bus.score1, 0);
        chk("rr_over", bus.match_over, 0);
        chk("rr_champ", bus.champion, 0);
        chk("rr_active", bus.active_player, 0);

        // reset during the roll strobe
        bus.btn_p0 = 1'b1;
        @(negedge clk);
        bus.btn_p0 = 1'b0;
        chk("mid_rb_on", bus.core_rb, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rb_off", bus.core_rb, 0);
        chk("mid_core_rst", bus.core_rst, 1);
        chk("mid_sum", bus.core_sum, 0);
        rst = 1'b0;
        @(negedge clk);
        exp_s0 = 0; exp_s1 = 0; exp_act = 0;

        roll(1'b0, 1'b1, 1'b0, 1'b0);
        exp_s0 = 1; exp_act = 1;
        expect_after(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dice_turn_scheduler.md
# dice_turn_scheduler

Two-player turn controller for the dual-dice game core.
- Generates the dice values and drives the core's `sum`, roll-strobe and round-reset inputs.
- Arbitrates the core between two players' roll buttons and keeps per-player round scores.
- Declares a match champion.
- Sits between the board-level button synchronizers and the game-core FSM.

## Interface
Parameters:
- `SCORE_W`, 4, width of each score counter.
- `WIN_SCORE`, 5, round wins needed to take the match (1..2^SCORE_W-1).
- `RB_CYC`, 2, cycles `core_rb` is held high per roll (≥1).
- `TIMEOUT_CYC`, 1024, idle cycles before a turn is forfeited (used only with the macro).

Ports. Clock is `clk`. Reset is `rst`: synchronous and active-high.
- `clk`, in, 1: single clock for all logic.
- `rst`, in, 1: synchronous, active-high reset.
- `btn_p0`, in, 1: player 0 roll button, already synchronized.
- `btn_p1`, in, 1: player 1 roll button, already synchronized.
- `core_win`, in, 1: win indication from the game core.
- `core_lose`, in, 1: lose indication from the game core.
- `core_sum`, out, 4: latched die_a+die_b, range 2..12.
- `core_rb`, out, 1: roll strobe to the core.
- `core_rst`, out, 1: round reset to the core.
- `die_a`, out, 3: latched die values, 1..6.
- `die_b`, out, 3: latched die values, 1..6.
- `active_player`, out, 1: player whose turn it is.
- `score0`, out, SCORE_W: round wins for player 0.
- `score1`, out, SCORE_W: round wins for player 1.
- `match_over`, out, 1: match finished.
- `champion`, out, 1: winning player; valid while `match_over` is high.

## Operation
Free-running roller:
- `ra` cycles 1→6→1 every clock.
- `rb_` advances 1→6→1 each time `ra` wraps.
- Together they cover all 36 combinations.

States: CLEAR, WAIT_BTN, STROBE, SETTLE, RESOLVE, OVER.
- **CLEAR:** `core_rst`=1 for one cycle → WAIT_BTN.
- **WAIT_BTN:** Waits for a rising edge of the active player's button (high this cycle, low the previous cycle).
  - On the edge, latch `die_a`←`ra`, `die_b`←`rb_`, and `core_sum`←`ra`+`rb_` (zero-extended to 4 bits) → STROBE.
  - The other player's button is ignored.
- **STROBE:** `core_rb`=1 for exactly RB_CYC cycles. `core_sum`, `die_a` and `die_b` stay stable → SETTLE.
- **SETTLE:** Sample `core_lose` and `core_win`.
  - `core_lose`: opponent score +1 → RESOLVE. `core_lose` has priority if both are high.
  - `core_win` alone: active player's score +1 → RESOLVE.
  - Neither (point phase): → WAIT_BTN with the same player.
- **RESOLVE:**
  - If the incremented score == WIN_SCORE: `champion`←that player → OVER.
  - Otherwise toggle `active_player` → CLEAR.
- **OVER:** `match_over`=1 and `core_rb`=0. All buttons are ignored until `rst`.

Arithmetic and boundary rules:
- Scores never exceed WIN_SCORE; no wrap is possible.
- Button held continuously produces one roll only; a new rising edge is needed.
- A button edge arriving during STROBE, SETTLE, RESOLVE or CLEAR is discarded, not queued.

## Timing
Reset values, while `rst` is high:
- State CLEAR, roller 1/1, `die_a`=`die_b`=1, `core_sum`=0.
- `core_rb`=0, `score0`=`score1`=0, `active_player`=0, `match_over`=0, `champion`=0.
- `core_rst`=1. It is combinational: `rst` OR (state==CLEAR).

First cycle after `rst` deasserts: `core_rst`=1 (CLEAR).

Roll latency, with the button edge sampled at cycle N:
- `core_sum` valid and `core_rb` high during N+1..N+RB_CYC.
- SETTLE at N+RB_CYC+1.
- Score visible at N+RB_CYC+2.
- `active_player` toggles at N+RB_CYC+3.

`rst` mid-operation (e.g. during STROBE): `core_rb` is low in the cycle after `rst` is sampled; scores clear.

## Configuration
`DICE_SCHED_TIMEOUT_EN`:
- **Defined:** A cycle counter runs in WAIT_BTN and clears on entry.
  - After TIMEOUT_CYC consecutive cycles with no valid edge, the turn passes: toggle `active_player` → CLEAR, no score change.
  - An edge on the exact timeout cycle wins; the roll proceeds.
- **Undefined:** WAIT_BTN waits indefinitely, and no counter is synthesized.

## Structure
- Package `dice_pkg`:
  - state enum `sched_state_t`
  - `DIE_W`=3
  - `SUM_W`=4
  - `DIE_MIN`=1 and `DIE_MAX`=6
- Sub-module `dice_roller`: the two chained mod-6 counters plus the latch-on-enable output registers.

## Test plan
- **Reset:** assert `rst` 3 cycles → all outputs hold their reset values; `core_rst`=1 on the first cycle after release, then 0.
- **Win round:** P0 edge, `core_win`=1 in SETTLE → `core_rb` high 2 cycles with `core_sum` = `die_a`+`die_b`; `score0`=1; `active_player`=1; one-cycle `core_rst` pulse.
- **Point phase and arbitration:** P0 rolls with neither `core_win` nor `core_lose` → back to WAIT_BTN with `active_player`=0; a `btn_p1` edge produces no `core_rb`.
- **Simultaneous indications:** `core_win` and `core_lose` both high in SETTLE on P1's turn → `score0`+1, `score1` unchanged.
- **Match end:** `score1` at 4 plus a P1 win → `score1`=5, `match_over`=1, `champion`=1; further edges give no `core_rb` until `rst`.
- **Timeout (macro on, TIMEOUT_CYC=16):** no press for 16 cycles → `active_player` toggles; scores unchanged; `core_rst` pulses.
